// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register busy scoreboard.
// Issue stalls on RAW/WAW hazards; a same-cycle writeback resolves them and is bypassed.
module regfile_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_wr,
  output logic [XLEN-1:0] rs1_v,
  output logic [XLEN-1:0] rs2_v,
  output logic            op_valid,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [NREG-1:0] busy_vec
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [XLEN-1:0] r_rs1_v;
  logic [XLEN-1:0] r_rs2_v;
  logic            r_op_valid;

  logic            w_hazard;
  logic            w_accept;
  logic            w_wb_en;
  logic            w_set_en;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [NREG-1:0] w_busy_nxt;

  // A register is only effectively busy if no writeback for it lands this cycle.
  function automatic logic f_eff_busy(input logic [NREG-1:0] busy, input logic [AW-1:0] a,
                                      input logic wbv, input logic [AW-1:0] wbrd);
    return busy[a] & ~(wbv & (wbrd == a));
  endfunction

  // Hazard detection, operand selection with writeback bypass, and next busy state.
  always_comb begin
    w_hazard = issue_valid & (f_eff_busy(r_busy, issue_rs1, wb_valid, wb_rd) |
                              f_eff_busy(r_busy, issue_rs2, wb_valid, wb_rd) |
                              (issue_wr & f_eff_busy(r_busy, issue_rd, wb_valid, wb_rd)));
    w_accept = issue_valid & ~w_hazard;
    w_wb_en  = wb_valid & (wb_rd != {AW{1'b0}});
    w_set_en = w_accept & issue_wr & (issue_rd != {AW{1'b0}});

    if (issue_rs1 == {AW{1'b0}}) begin
      w_rs1_val = {XLEN{1'b0}};
    end else if (wb_valid && (wb_rd == issue_rs1)) begin
      w_rs1_val = wb_data;
    end else begin
      w_rs1_val = r_regs[issue_rs1];
    end

    if (issue_rs2 == {AW{1'b0}}) begin
      w_rs2_val = {XLEN{1'b0}};
    end else if (wb_valid && (wb_rd == issue_rs2)) begin
      w_rs2_val = wb_data;
    end else begin
      w_rs2_val = r_regs[issue_rs2];
    end

    // An accepted issue setting busy[rd] wins over a writeback clearing it.
    w_busy_nxt    = {NREG{1'b0}};
    w_busy_nxt[0] = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      w_busy_nxt[i] = (w_set_en & (issue_rd == AW'(i))) |
                      (r_busy[i] & ~(w_wb_en & (wb_rd == AW'(i))));
    end
  end

  // Register array, scoreboard and registered operand outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
      r_busy     <= {NREG{1'b0}};
      r_rs1_v    <= {XLEN{1'b0}};
      r_rs2_v    <= {XLEN{1'b0}};
      r_op_valid <= 1'b0;
    end else begin
      if (w_wb_en) begin
        r_regs[wb_rd] <= wb_data;
      end
      r_busy     <= w_busy_nxt;
      r_op_valid <= w_accept;
      if (w_accept) begin
        r_rs1_v <= w_rs1_val;
        r_rs2_v <= w_rs2_val;
      end
    end
  end

  assign issue_ready = ~w_hazard;
  assign rs1_v       = r_rs1_v;
  assign rs2_v       = r_rs2_v;
  assign op_valid    = r_op_valid;
  assign busy_vec    = r_busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a behavioural register/busy model checked
// on every falling edge, plus hand-computed expectations for each scenario.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rstn;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_wr;
  logic [31:0] rs1_v;
  logic [31:0] rs2_v;
  logic        op_valid;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] busy_vec;

  int n_vec = 0;
  int n_err = 0;
  logic last_ready;

  regfile_scoreboard #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .clk(clk), .rstn(rstn),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_wr(issue_wr),
    .rs1_v(rs1_v), .rs2_v(rs2_v), .op_valid(op_valid),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic [31:0] m_rs1;
  logic [31:0] m_rs2;
  logic        m_opv;

  function automatic bit m_eb(input logic [4:0] a);
    return m_busy[a] && !(wb_valid && wb_rd == a);
  endfunction

  function automatic bit m_ready();
    return !(issue_valid && (m_eb(issue_rs1) || m_eb(issue_rs2) || (issue_wr && m_eb(issue_rd))));
  endfunction

  function automatic logic [31:0] m_opnd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_valid && wb_rd == a) return wb_data;
    return m_regs[a];
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      m_busy <= 32'd0;
      m_rs1  <= 32'd0;
      m_rs2  <= 32'd0;
      m_opv  <= 1'b0;
    end else begin
      if (issue_valid && m_ready()) begin
        m_opv <= 1'b1;
        m_rs1 <= m_opnd(issue_rs1);
        m_rs2 <= m_opnd(issue_rs2);
      end else begin
        m_opv <= 1'b0;
      end
      if (wb_valid && wb_rd != 5'd0) begin
        m_regs[wb_rd] <= wb_data;
        m_busy[wb_rd] <= 1'b0;
      end
      if (issue_valid && m_ready() && issue_wr && issue_rd != 5'd0)
        m_busy[issue_rd] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("m_issue_ready", {31'd0, issue_ready}, {31'd0, m_ready()});
    chk("m_op_valid", {31'd0, op_valid}, {31'd0, m_opv});
    chk("m_rs1_v", rs1_v, m_rs1);
    chk("m_rs2_v", rs2_v, m_rs2);
    chk("m_busy_vec", busy_vec, m_busy);
  end

  // Drive one cycle of inputs, sample issue_ready mid-cycle, return just after the edge.
  task automatic apply(input bit v, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                       input bit w, input bit wv, input logic [4:0] wr_a, input logic [31:0] wd);
    issue_valid = v; issue_rs1 = a1; issue_rs2 = a2; issue_rd = d; issue_wr = w;
    wb_valid = wv; wb_rd = wr_a; wb_data = wd;
    #2 last_ready = issue_ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    issue_valid = 1'b0; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0; issue_wr = 1'b0;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    #2;
    chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_ready", {31'd0, issue_ready}, 32'd1);
    chk("rst_rs1", rs1_v, 32'd0);
    #10 rstn = 1'b1;
    @(posedge clk); #1;

    // Basic issue from reset
    apply(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("t1_ready", {31'd0, last_ready}, 32'd1);
    chk("t1_op_valid", {31'd0, op_valid}, 32'd1);
    chk("t1_rs1", rs1_v, 32'd0);
    chk("t1_busy", busy_vec, 32'h0000_0020);

    // Writeback then read back
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 32'h0000_00AA);
    chk("t2_op_valid_idle", {31'd0, op_valid}, 32'd0);
    apply(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("t2_rs1", rs1_v, 32'h0000_00AA);
    chk("t2_rs2", rs2_v, 32'd0);
    chk("t2_busy", busy_vec, 32'h0000_0020);

    // RAW stall, then resolved by same-cycle writeback with bypass
    apply(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("t3_stall_ready", {31'd0, last_ready}, 32'd0);
    chk("t3_stall_op_valid", {31'd0, op_valid}, 32'd0);
    chk("t3_hold_rs1", rs1_v, 32'h0000_00AA);
    apply(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
    chk("t3_byp_ready", {31'd0, last_ready}, 32'd1);
    chk("t3_byp_rs1", rs1_v, 32'h0000_1234);
    chk("t3_byp_busy", busy_vec, 32'd0);

    // WAW with same-cycle writeback: set wins, value still written
    apply(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("t4_busy9", busy_vec, 32'h0000_0200);
    apply(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 5'd9, 32'h0000_0055);
    chk("t4_ready", {31'd0, last_ready}, 32'd1);
    chk("t4_set_wins", busy_vec, 32'h0000_0200);
    chk("t4_reg9", dut.r_regs[9], 32'h0000_0055);
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd9, 32'h0000_0066);

    // x0 behaviour
    apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    chk("t5_rs1", rs1_v, 32'd0);
    chk("t5_rs2", rs2_v, 32'd0);
    chk("t5_busy", busy_vec, 32'd0);

    // rd equal to rs1/rs2: no self-stall, both operands identical
    apply(1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("t6_ready", {31'd0, last_ready}, 32'd1);
    chk("t6_rs1", rs1_v, 32'h0000_00AA);
    chk("t6_rs2", rs2_v, 32'h0000_00AA);
    chk("t6_busy", busy_vec, 32'h0000_0080);
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 32'h0000_00AA);

    // Back-to-back writebacks with reads of the previous register
    for (int i = 10; i < 16; i++) begin
      apply(1'b1, 5'(i - 1), 5'(i), 5'd0, 1'b0, 1'b1, 5'(i), 32'h0000_0011 * 32'(i));
    end
    chk("t7_rs1", rs1_v, 32'h0000_0011 * 32'd14);
    chk("t7_rs2", rs2_v, 32'h0000_0011 * 32'd15);

    // Mid-cycle asynchronous reset
    apply(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 5'd0, 32'd0);
    apply(1'b1, 5'd7, 5'd0, 5'd6, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("t8_pre_busy", busy_vec, 32'h0000_0044);
    chk("t8_pre_op_valid", {31'd0, op_valid}, 32'd1);
    issue_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("t8_rst_busy", busy_vec, 32'd0);
    chk("t8_rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("t8_rst_rs1", rs1_v, 32'd0);
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    apply(1'b1, 5'd6, 5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("t8_ready", {31'd0, last_ready}, 32'd1);
    chk("t8_rs1", rs1_v, 32'd0);
    chk("t8_rs2", rs2_v, 32'd0);
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
